ccd_adc_line_capture: RTL

//  Parametrised CCD line capture front end for a pipelined ADC (AD9235 class).

---
 rtl/ccd_adc_line_capture_if.sv | 26 ++
 rtl/ccd_adc_line_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ccd_adc_line_capture_if.sv
// Pixel output stream of the CCD line capture: FWFT head word, valid/ready, end-of-line tag.
// Latency: none, wires only.
// Backpressure: consumer holds pixel_ready low and the producer keeps the head word stable.
// Ports: pixel_data (word), pixel_valid (head present), pixel_ready (consumer accepts), pixel_last (final pixel of line).
interface ccd_adc_line_capture_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_valid;
  logic              pixel_ready;
  logic              pixel_last;

  modport master (
    output pixel_data,
    output pixel_valid,
    output pixel_last,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    input  pixel_last,
    output pixel_ready
  );
endinterface

// File: rtl/ccd_adc_line_capture.sv
// CCD line capture: regenerates adcclk, drops ADC pipeline samples, averages dark pixels, outputs offset-corrected active pixels.
// Latency: cdsclk1 rise to pixel_valid is SYNC_STAGES+3 clk with an empty output FIFO.
// Backpressure: small FWFT FIFO absorbs stalls; a push into a full FIFO without a pop is dropped and sets sticky overflow_o.
// Ports: clk, rst_n (async active-low); cdsclk1_i, adc_data_i, line_start_i, offset_en_i, ovf_clr_i in;
//        adcclk_o, dark_level_o, line_busy_o, overflow_o out; pix_if (master) carries the pixel stream.
module ccd_adc_line_capture #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2,
  parameter int ADC_LAT     = 7,
  parameter int DARK_LOG2   = 4,
  parameter int ACTIVE_PIX  = 3648,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cdsclk1_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              line_start_i,
  input  logic              offset_en_i,
  input  logic              ovf_clr_i,
  output logic              adcclk_o,
  output logic [DATA_W-1:0] dark_level_o,
  output logic              line_busy_o,
  output logic              overflow_o,
  ccd_adc_line_capture_if.master pix_if
);

  localparam int DARK_N  = 1 << DARK_LOG2;
  localparam int ACC_W   = DATA_W + DARK_LOG2;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int MAX_AB  = (ADC_LAT > DARK_N) ? ADC_LAT : DARK_N;
  localparam int CNT_MAX = (MAX_AB > ACTIVE_PIX) ? MAX_AB : ACTIVE_PIX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((ADC_LAT > 0) ? ADC_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] DARK_LAST  = CNT_W'(DARK_N - 1);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(ACTIVE_PIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_DARK,
    ST_ACTIVE
  } state_t;

  // Restart target skips the flush phase entirely when the ADC has no pipeline delay.
  localparam state_t START_ST = (ADC_LAT == 0) ? ST_DARK : ST_FLUSH;

  // ---------------- cdsclk1 capture ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   smp_q;
  logic                   evt_q;
  logic [DATA_W-1:0]      s_reg_q;
  logic                   adcclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      smp_q       <= 1'b0;
      evt_q       <= 1'b0;
      s_reg_q     <= '0;
      adcclk_q    <= 1'b0;
    end else begin
      adcclk_q    <= cdsclk1_i;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], cdsclk1_i};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      smp_q       <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
      evt_q       <= smp_q;
      if (smp_q) begin
        s_reg_q <= adc_data_i;
      end
    end
  end

  assign adcclk_o = adcclk_q;

  // ---------------- line FSM ----------------
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [DATA_W-1:0] dark_level_q;
  logic              busy_q;

  assign acc_d = acc_q + ACC_W'(s_reg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      dark_level_q <= '0;
      busy_q       <= 1'b0;
    end else if (line_start_i) begin
      // Restart from any state; a coincident evt is deliberately not counted.
      state_q <= START_ST;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b1;
    end else if (evt_q) begin
      case (state_q)
        ST_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_q <= ST_DARK;
            cnt_q   <= '0;
            acc_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DARK: begin
          if (cnt_q == DARK_LAST) begin
            dark_level_q <= DATA_W'(acc_d >> DARK_LOG2);
            state_q      <= ST_ACTIVE;
            cnt_q        <= '0;
            acc_q        <= '0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          // Leaves ACTIVE on the final pixel whether or not the FIFO accepted it.
          if (cnt_q == ACT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dark_level_o = dark_level_q;
  assign line_busy_o  = busy_q;

  // ---------------- pixel word formation ----------------
  logic              push_vld;
  logic [DATA_W-1:0] push_dat;
  logic              push_last;

  always_comb begin
    push_vld  = evt_q & ~line_start_i & (state_q == ST_ACTIVE);
    push_last = (cnt_q == ACT_LAST);
    push_dat  = s_reg_q;
    if (offset_en_i) begin
      // Clamp at zero so pixels darker than the black level never wrap.
      push_dat = (s_reg_q > dark_level_q) ? (s_reg_q - dark_level_q) : '0;
    end
  end

  // ---------------- output FIFO (FWFT) ----------------
  logic [DATA_W-1:0] mem_dat_q  [FIFO_DEPTH];
  logic              mem_last_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic              overflow_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & pix_if.pixel_ready;
  // A simultaneous pop frees the head slot, which is the slot a full FIFO writes next.
  assign wr_en      = push_vld & (~fifo_full | pop);
  assign drop       = push_vld & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dat_q[i]  <= '0;
        mem_last_q[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_dat_q[wr_ptr_q[AW-1:0]]  <= push_dat;
        mem_last_q[wr_ptr_q[AW-1:0]] <= push_last;
        wr_ptr_q                     <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign overflow_o         = overflow_q;
  assign pix_if.pixel_valid = ~fifo_empty;
  assign pix_if.pixel_data  = mem_dat_q[rd_ptr_q[AW-1:0]];
  assign pix_if.pixel_last  = mem_last_q[rd_ptr_q[AW-1:0]];

endmodule
